// File: rtl/comb_sweep_ctrl_if.sv
// Signals between the sweep controller, its host and the four comb instances.
// The host/bench side uses master; the controller uses slave.
interface comb_sweep_ctrl_if;
  logic        start;
  logic        Y1;
  logic        Y2;
  logic        Y3;
  logic        Y4;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic        busy;
  logic        done;
  logic [15:0] truth_tbl;
  logic [4:0]  err_cnt;
  logic        first_err_valid;
  logic [3:0]  first_err_vec;

  modport master (
    output start, Y1, Y2, Y3, Y4,
    input  A, B, C, D, busy, done, truth_tbl, err_cnt, first_err_valid, first_err_vec
  );

  modport slave (
    input  start, Y1, Y2, Y3, Y4,
    output A, B, C, D, busy, done, truth_tbl, err_cnt, first_err_valid, first_err_vec
  );
endinterface

// File: rtl/comb_sweep_ctrl.sv
// Drives {A,B,C,D} through vectors 0..15, records Y1 as the truth table and
// counts vectors where any of Y2..Y4 disagrees with Y1.
module comb_sweep_ctrl #(
  parameter int SETTLE = 2
) (
  input logic              clk,
  input logic              rst_n,
  comb_sweep_ctrl_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_e;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tbl_q, tbl_d;
  logic [4:0]  err_cnt_q, err_cnt_d;
  logic        fe_valid_q, fe_valid_d;
  logic [3:0]  fe_vec_q, fe_vec_d;

  function automatic logic any_mismatch(input logic y1, input logic y2,
                                        input logic y3, input logic y4);
    return (y2 != y1) | (y3 != y1) | (y4 != y1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      tbl_q      <= '0;
      err_cnt_q  <= '0;
      fe_valid_q <= 1'b0;
      fe_vec_q   <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      tbl_q      <= tbl_d;
      err_cnt_q  <= err_cnt_d;
      fe_valid_q <= fe_valid_d;
      fe_vec_q   <= fe_vec_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    tbl_d      = tbl_q;
    err_cnt_d  = err_cnt_q;
    fe_valid_d = fe_valid_q;
    fe_vec_d   = fe_vec_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          tbl_d      = '0;
          err_cnt_d  = '0;
          fe_valid_d = 1'b0;
          fe_vec_d   = '0;
          vec_d      = '0;
          cnt_d      = '0;
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        tbl_d[vec_q] = bus.Y1;
        if (any_mismatch(bus.Y1, bus.Y2, bus.Y3, bus.Y4)) begin
          err_cnt_d = err_cnt_q + 5'd1;
          if (!fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_vec_d   = vec_q;
          end
        end
        if (vec_q == 4'd15) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 4'd1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        // Stimulus parks at vector 0 while idle.
        vec_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign {bus.A, bus.B, bus.C, bus.D} = vec_q;
  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.done            = (state_q == ST_DONE);
  assign bus.truth_tbl       = tbl_q;
  assign bus.err_cnt         = err_cnt_q;
  assign bus.first_err_valid = fe_valid_q;
  assign bus.first_err_vec   = fe_vec_q;
endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// Bench for comb_sweep_ctrl: two instances (SETTLE=2 and SETTLE=1) fed by a
// reference Y=(A&B)|(C&D) model with selectable faults on Y3/Y4.
module tb_comb_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   mode;  // 0: all agree, 1: Y3 stuck at 0, 2: Y4 = ~Y1
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  comb_sweep_ctrl_if ifa ();
  comb_sweep_ctrl_if ifb ();

  comb_sweep_ctrl #(.SETTLE(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  comb_sweep_ctrl #(.SETTLE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  function automatic logic ref_y(input logic a, input logic b, input logic c, input logic d);
    return (a & b) | (c & d);
  endfunction

  assign ifa.Y1 = ref_y(ifa.A, ifa.B, ifa.C, ifa.D);
  assign ifa.Y2 = ref_y(ifa.A, ifa.B, ifa.C, ifa.D);
  assign ifa.Y3 = (mode == 1) ? 1'b0 : ref_y(ifa.A, ifa.B, ifa.C, ifa.D);
  assign ifa.Y4 = (mode == 2) ? ~ref_y(ifa.A, ifa.B, ifa.C, ifa.D) : ref_y(ifa.A, ifa.B, ifa.C, ifa.D);
  assign ifb.Y1 = ref_y(ifb.A, ifb.B, ifb.C, ifb.D);
  assign ifb.Y2 = ref_y(ifb.A, ifb.B, ifb.C, ifb.D);
  assign ifb.Y3 = (mode == 1) ? 1'b0 : ref_y(ifb.A, ifb.B, ifb.C, ifb.D);
  assign ifb.Y4 = (mode == 2) ? ~ref_y(ifb.A, ifb.B, ifb.C, ifb.D) : ref_y(ifb.A, ifb.B, ifb.C, ifb.D);

  typedef struct packed {
    logic [3:0]  abcd;
    logic        busy;
    logic        done;
    logic [15:0] tbl;
    logic [4:0]  err;
    logic        fev;
    logic [3:0]  fvec;
  } obs_t;

  typedef struct {
    int          inst;
    int          mode;
    bit          pulses;
    logic [15:0] tbl;
    logic [4:0]  err;
    logic        fev;
    logic [3:0]  fvec;
    int          done_cyc;
  } vec_t;

  vec_t tests[6];
  vec_t exp_q[$];

  function automatic obs_t obs(input int inst);
    obs_t o;
    if (inst == 0) begin
      o.abcd = {ifa.A, ifa.B, ifa.C, ifa.D};
      o.busy = ifa.busy;  o.done = ifa.done;  o.tbl = ifa.truth_tbl;
      o.err  = ifa.err_cnt;  o.fev = ifa.first_err_valid;  o.fvec = ifa.first_err_vec;
    end else begin
      o.abcd = {ifb.A, ifb.B, ifb.C, ifb.D};
      o.busy = ifb.busy;  o.done = ifb.done;  o.tbl = ifb.truth_tbl;
      o.err  = ifb.err_cnt;  o.fev = ifb.first_err_valid;  o.fvec = ifb.first_err_vec;
    end
    return o;
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) ifa.start = v;
    else           ifb.start = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero_state(input string name, input int inst);
    obs_t o;
    o = obs(inst);
    chk({name, "_abcd"}, 32'(o.abcd), 32'd0);
    chk({name, "_busy"}, 32'(o.busy), 32'd0);
    chk({name, "_done"}, 32'(o.done), 32'd0);
    chk({name, "_tbl"},  32'(o.tbl),  32'd0);
    chk({name, "_err"},  32'(o.err),  32'd0);
    chk({name, "_fev"},  32'(o.fev),  32'd0);
    chk({name, "_fvec"}, 32'(o.fvec), 32'd0);
  endtask

  // Vector expected on A..D in cycle i after the start edge.
  function automatic logic [3:0] exp_abcd(input int i, input int settle);
    if (i <= 16 * (settle + 1)) return 4'((i - 1) / (settle + 1));
    return 4'd15;
  endfunction

  task automatic run_sweep(input vec_t t);
    obs_t o;
    vec_t e;
    int   settle;
    int   done_at;
    int   n_done;
    int   trace_err;
    settle    = (t.inst == 0) ? 2 : 1;
    done_at   = 0;
    n_done    = 0;
    trace_err = 0;
    mode      = t.mode;
    exp_q.push_back(t);
    @(negedge clk);
    set_start(t.inst, 1'b1);
    @(negedge clk);
    set_start(t.inst, 1'b0);
    for (int i = 1; i <= 120; i++) begin
      o = obs(t.inst);
      if (i == 1) chk("busy_after_start", 32'(o.busy), 32'd1);
      if (done_at == 0 && !o.done) begin
        if (o.abcd !== exp_abcd(i, settle) || o.busy !== 1'b1) trace_err++;
      end
      if (o.done === 1'b1) begin
        n_done++;
        if (done_at == 0) begin
          done_at = i;
          if (o.abcd !== 4'd15 || o.busy !== 1'b1) trace_err++;
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("truth_tbl", 32'(o.tbl), 32'(e.tbl));
            chk("err_cnt", 32'(o.err), 32'(e.err));
            chk("first_err_valid", 32'(o.fev), 32'(e.fev));
            chk("first_err_vec", 32'(o.fvec), 32'(e.fvec));
          end
        end
      end
      if (done_at != 0 && i == done_at + 1) begin
        chk("busy_after_done", 32'(o.busy), 32'd0);
        chk("abcd_after_done", 32'(o.abcd), 32'd0);
        chk("tbl_held_idle", 32'(o.tbl), 32'(t.tbl));
      end
      if (done_at != 0 && i == done_at + 4) begin
        chk("no_restart", 32'(o.busy), 32'd0);
        break;
      end
      // Extra start pulses mid-sweep and on the done cycle must be ignored.
      set_start(t.inst, (t.pulses && (i == 10 || o.done === 1'b1)) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    set_start(t.inst, 1'b0);
    chk("done_cycle", 32'(done_at), 32'(t.done_cyc));
    chk("done_pulses", 32'(n_done), 32'd1);
    chk("stimulus_trace_errs", 32'(trace_err), 32'd0);
  endtask

  initial begin
    obs_t o;
    tests[0] = '{inst:0, mode:0, pulses:1'b0, tbl:16'hF888, err:5'd0,  fev:1'b0, fvec:4'd0, done_cyc:49};
    tests[1] = '{inst:0, mode:1, pulses:1'b0, tbl:16'hF888, err:5'd7,  fev:1'b1, fvec:4'd3, done_cyc:49};
    tests[2] = '{inst:0, mode:2, pulses:1'b0, tbl:16'hF888, err:5'd16, fev:1'b1, fvec:4'd0, done_cyc:49};
    tests[3] = '{inst:0, mode:0, pulses:1'b1, tbl:16'hF888, err:5'd0,  fev:1'b0, fvec:4'd0, done_cyc:49};
    tests[4] = '{inst:1, mode:0, pulses:1'b0, tbl:16'hF888, err:5'd0,  fev:1'b0, fvec:4'd0, done_cyc:33};
    tests[5] = '{inst:1, mode:1, pulses:1'b1, tbl:16'hF888, err:5'd7,  fev:1'b1, fvec:4'd3, done_cyc:33};

    mode      = 0;
    rst_n     = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_state("reset_a", 0);
    chk_zero_state("reset_b", 1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_sweep(tests[k]);

    // Reset in cycle 20 of a faulty sweep: vectors 0..5 sampled, one error at vector 3.
    mode = 1;
    @(negedge clk);
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    repeat (19) @(negedge clk);
    o = obs(0);
    chk("pre_reset_err", 32'(o.err), 32'd1);
    chk("pre_reset_tbl", 32'(o.tbl), 32'h0008);
    chk("pre_reset_busy", 32'(o.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero_state("midsweep_reset", 0);
    @(negedge clk);
    chk("reset_stays_idle", 32'(obs(0).busy), 32'd0);
    run_sweep(tests[0]);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
